vga_timing: RTL and testbench
=============================

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 The block SHALL have parameter H_VISIBLE, default 800, meaning active pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 40, meaning horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 128, meaning hsync width in pixels.
REQ-004 The block SHALL have parameter H_BP, default 88, meaning horizontal back porch in pixels, giving H_TOTAL 1056.
REQ-005 The block SHALL have parameter V_VISIBLE, default 600, meaning active lines per frame.
REQ-006 The block SHALL have parameter V_FP, default 1, meaning vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 4, meaning vsync width in lines.
REQ-008 The block SHALL have parameter V_BP, default 23, meaning vertical back porch in lines, giving V_TOTAL 628.
REQ-009 The block SHALL have port clk, input, 1, pixel clock (40 MHz for defaults).
REQ-010 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-011 The block SHALL have port hcount_out, output, 11, current pixel column 0..H_TOTAL-1.
REQ-012 The block SHALL have port vcount_out, output, 11, current line 0..V_TOTAL-1.
REQ-013 The block SHALL have ports hsync_out and vsync_out, output, 1 each, active-high sync pulses.
REQ-014 The block SHALL have ports hblnk_out and vblnk_out, output, 1 each, high outside the visible area.
REQ-015 The block SHALL have port frame_start, output, 1, one-cycle pulse at pixel (0,0).
REQ-016 The block SHALL have port frame_cnt, output, 16, frames completed since reset.

Function
REQ-017 hcount SHALL increment by 1 every clk and wrap from H_TOTAL-1 to 0.
REQ-018 vcount SHALL increment by 1 on each hcount wrap, wrap from V_TOTAL-1 to 0 when both counters wrap in the same cycle, and otherwise hold.
REQ-019 Every output SHALL be a register and be mutually aligned: each flag describes the hcount_out/vcount_out value presented in the same cycle.
REQ-020 The alignment in REQ-019 SHALL be achieved by decoding all flags from the next-state counter values.
REQ-021 hblnk_out SHALL be 1 iff hcount_out >= H_VISIBLE; vblnk_out SHALL be 1 iff vcount_out >= V_VISIBLE.
REQ-022 hsync_out SHALL be 1 iff H_VISIBLE+H_FP <= hcount_out < H_VISIBLE+H_FP+H_SYNC (840..967 for defaults).
REQ-023 vsync_out SHALL be 1 iff V_VISIBLE+V_FP <= vcount_out < V_VISIBLE+V_FP+V_SYNC (601..604 for defaults); it is a whole-line quantity and SHALL change only on hcount wrap.
REQ-024 frame_start SHALL be 1 for exactly the one cycle in which hcount_out=0 and vcount_out=0, including the first cycle after reset release.
REQ-025 frame_cnt SHALL increment by 1 on every vcount wrap to 0, wrapping 65535 -> 0.
REQ-026 All comparisons SHALL be performed at 11-bit unsigned width with no truncation for any parameter set whose totals are <= 2047.

Reset
REQ-027 While rst=0, all outputs SHALL be forced immediately and asynchronously to their reset values: hcount_out=0, vcount_out=0, hsync_out=0, vsync_out=0, hblnk_out=0, vblnk_out=0, frame_start=1, frame_cnt=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame; frame_cnt SHALL NOT increment for it.
REQ-029 After rst deasserts, the first rising clk SHALL present hcount_out=1, vcount_out=0, frame_start=0.

Configuration
REQ-030 The frame counter SHALL be compiled in only when macro VGA_TIMING_FRAME_CNT_EN is defined; without it, frame_cnt SHALL be constant 0 and no counter flops SHALL be inferred.

Structure
REQ-031 Default timing constants and derived totals/sync bounds for 800x600@60 SHALL live in shared package vga_pkg, for reuse by downstream overlay stages.
REQ-032 A single sub-module, vga_counter (parameterised modulo-N 11-bit counter with wrap output), SHALL be instantiated once for horizontal and once for vertical.

Verification
REQ-033 The bench SHALL release reset and check hcount_out sequence 0,1,...,1055,0 with vcount_out stepping 0 -> 1 in the cycle hcount_out returns to 0.
REQ-034 The bench SHALL check that hsync_out is high for exactly 128 cycles per line, rising when hcount_out=840 and falling when hcount_out=968.
REQ-035 The bench SHALL check at line 600 that vblnk_out=1 and at line 601 that vsync_out=1 for 4 full lines (601..604), low at 605.
REQ-036 The bench SHALL run 3 frames and check frame_start pulses every 663168 cycles, with frame_cnt reading 3 after the third wrap.
REQ-037 The bench SHALL assert rst at hcount=500, vcount=300 and check all outputs reach reset values without waiting for a clk edge, with frame_cnt restarting at 0.
REQ-038 The bench SHALL rebuild without VGA_TIMING_FRAME_CNT_EN and check frame_cnt stays 0 over 2 frames while the timing is unchanged.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared 800x600@60 timing constants and 11-bit coordinate helpers, reused by
// vga_timing and by downstream overlay stages.
package vga_pkg;

    localparam int COORD_W = 11;
    typedef logic [COORD_W-1:0] vga_coord_t;

    localparam int DEF_H_VISIBLE = 800;
    localparam int DEF_H_FP      = 40;
    localparam int DEF_H_SYNC    = 128;
    localparam int DEF_H_BP      = 88;
    localparam int DEF_V_VISIBLE = 600;
    localparam int DEF_V_FP      = 1;
    localparam int DEF_V_SYNC    = 4;
    localparam int DEF_V_BP      = 23;

    localparam int DEF_H_TOTAL    = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL    = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_HS_START   = DEF_H_VISIBLE + DEF_H_FP;
    localparam int DEF_HS_END     = DEF_HS_START + DEF_H_SYNC;
    localparam int DEF_VS_START   = DEF_V_VISIBLE + DEF_V_FP;
    localparam int DEF_VS_END     = DEF_VS_START + DEF_V_SYNC;

    // Half-open interval test [lo, hi) at full coordinate width.
    function automatic logic in_span(input vga_coord_t value, input vga_coord_t lo,
                                     input vga_coord_t hi);
        return (value >= lo) && (value < hi);
    endfunction

endpackage

// File: rtl/vga_counter.sv
// Modulo-N 11-bit counter with enable; exposes its next-state value and a
// combinational wrap strobe so the parent can decode flags one cycle early.
module vga_counter
    import vga_pkg::*;
#(
    parameter int N = DEF_H_TOTAL
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    output vga_coord_t o_count,
    output vga_coord_t o_next,
    output logic       o_wrap
);

    localparam vga_coord_t LAST = vga_coord_t'(N - 1);

    vga_coord_t r_count;

    assign o_wrap  = i_en && (r_count == LAST);
    assign o_count = r_count;

    always_comb begin
        o_next = r_count;
        if (o_wrap) begin
            o_next = '0;
        end else if (i_en) begin
            o_next = r_count + vga_coord_t'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= o_next;
        end
    end

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator: registered counters with sync/blank flags aligned to them.
// Define VGA_TIMING_FRAME_CNT_EN to build the 16-bit completed-frame counter.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam vga_coord_t HB_START = vga_coord_t'(H_VISIBLE);
    localparam vga_coord_t HS_START = vga_coord_t'(H_VISIBLE + H_FP);
    localparam vga_coord_t HS_END   = vga_coord_t'(H_VISIBLE + H_FP + H_SYNC);
    localparam vga_coord_t VB_START = vga_coord_t'(V_VISIBLE);
    localparam vga_coord_t VS_START = vga_coord_t'(V_VISIBLE + V_FP);
    localparam vga_coord_t VS_END   = vga_coord_t'(V_VISIBLE + V_FP + V_SYNC);

    vga_coord_t w_h_next;
    vga_coord_t w_v_next;
    logic       w_h_wrap;
    logic       w_v_wrap;

    logic r_hsync;
    logic r_vsync;
    logic r_hblnk;
    logic r_vblnk;
    logic r_frame_start;

    vga_counter #(.N(H_TOTAL)) u_hcnt (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_en    (1'b1),
        .o_count (hcount_out),
        .o_next  (w_h_next),
        .o_wrap  (w_h_wrap)
    );

    vga_counter #(.N(V_TOTAL)) u_vcnt (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_en    (w_h_wrap),
        .o_count (vcount_out),
        .o_next  (w_v_next),
        .o_wrap  (w_v_wrap)
    );

    // Flags are decoded from the counters' next values so they land together with them.
    // Outside reset, (0,0) is only ever reached through a vertical wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_hblnk       <= 1'b0;
            r_vblnk       <= 1'b0;
            r_frame_start <= 1'b1;
        end else begin
            r_hsync       <= in_span(w_h_next, HS_START, HS_END);
            r_vsync       <= in_span(w_v_next, VS_START, VS_END);
            r_hblnk       <= (w_h_next >= HB_START);
            r_vblnk       <= (w_v_next >= VB_START);
            r_frame_start <= w_v_wrap;
        end
    end

    assign hsync_out   = r_hsync;
    assign vsync_out   = r_vsync;
    assign hblnk_out   = r_hblnk;
    assign vblnk_out   = r_vblnk;
    assign frame_start = r_frame_start;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_cnt <= '0;
        end else if (w_v_wrap) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a default-timing instance for line-level checks and a
// small-raster instance for multi-frame, vertical and reset checks.
module tb_vga_timing;

    localparam int DHV = 800, DHF = 40, DHS = 128, DHB = 88;
    localparam int DVV = 600, DVF = 1,  DVS = 4,   DVB = 23;
    localparam int SHV = 20,  SHF = 2,  SHS = 4,   SHB = 6;
    localparam int SVV = 10,  SVF = 1,  SVS = 2,   SVB = 3;
    localparam int S_FRAME = (SHV + SHF + SHS + SHB) * (SVV + SVF + SVS + SVB);

`ifdef VGA_TIMING_FRAME_CNT_EN
    localparam bit FC_EN = 1'b1;
`else
    localparam bit FC_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [10:0] d_hc, d_vc, s_hc, s_vc;
    logic        d_hs, d_vs, d_hb, d_vb, d_fs;
    logic        s_hs, s_vs, s_hb, s_vb, s_fs;
    logic [15:0] d_fc, s_fc;

    vga_timing dut_def (
        .clk(clk), .rst(rst),
        .hcount_out(d_hc), .vcount_out(d_vc),
        .hsync_out(d_hs), .vsync_out(d_vs),
        .hblnk_out(d_hb), .vblnk_out(d_vb),
        .frame_start(d_fs), .frame_cnt(d_fc)
    );

    vga_timing #(
        .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_VISIBLE(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
    ) dut_sm (
        .clk(clk), .rst(rst),
        .hcount_out(s_hc), .vcount_out(s_vc),
        .hsync_out(s_hs), .vsync_out(s_vs),
        .hblnk_out(s_hb), .vblnk_out(s_vb),
        .frame_start(s_fs), .frame_cnt(s_fc)
    );

    // Clock edges seen since reset release: the whole reference model hangs off this.
    int unsigned t = 0;
    always @(posedge clk or negedge rst) begin
        if (!rst) t <= 0;
        else      t <= t + 1;
    end

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];
    int   hs_cnt, vs_cnt;
    logic prev_dhs, prev_svs;
    logic [10:0] prev_dhc, prev_dvc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, got, exp, t);
        end
    endtask

    // Reference: position and frame number follow from t by plain division.
    task automatic check_dut(input string nm,
                             input int hv, input int hf, input int hs, input int hb,
                             input int vv, input int vf, input int vs, input int vb,
                             input logic [10:0] hc, input logic [10:0] vc,
                             input logic hsy, input logic vsy, input logic hbl,
                             input logic vbl, input logic fs, input logic [15:0] fc);
        int ht, vt, h, v, ln, fr;
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        h  = int'(t % ht);
        ln = int'(t / ht);
        v  = ln % vt;
        fr = ln / vt;
        check_val({nm, ".hcount"}, 32'(hc),  32'(h));
        check_val({nm, ".vcount"}, 32'(vc),  32'(v));
        check_val({nm, ".hsync"},  32'(hsy), 32'(h >= hv + hf && h < hv + hf + hs));
        check_val({nm, ".vsync"},  32'(vsy), 32'(v >= vv + vf && v < vv + vf + vs));
        check_val({nm, ".hblnk"},  32'(hbl), 32'(h >= hv));
        check_val({nm, ".vblnk"},  32'(vbl), 32'(v >= vv));
        check_val({nm, ".fstart"}, 32'(fs),  32'(h == 0 && v == 0));
        check_val({nm, ".fcnt"},   32'(fc),  FC_EN ? 32'(fr % 65536) : 32'd0);
    endtask

    task automatic check_reset(input string nm, input logic [10:0] hc, input logic [10:0] vc,
                               input logic hsy, input logic vsy, input logic hbl,
                               input logic vbl, input logic fs, input logic [15:0] fc);
        check_val({nm, ".rst_hcount"}, 32'(hc),  32'd0);
        check_val({nm, ".rst_vcount"}, 32'(vc),  32'd0);
        check_val({nm, ".rst_hsync"},  32'(hsy), 32'd0);
        check_val({nm, ".rst_vsync"},  32'(vsy), 32'd0);
        check_val({nm, ".rst_hblnk"},  32'(hbl), 32'd0);
        check_val({nm, ".rst_vblnk"},  32'(vbl), 32'd0);
        check_val({nm, ".rst_fstart"}, 32'(fs),  32'd1);
        check_val({nm, ".rst_fcnt"},   32'(fc),  32'd0);
    endtask

    task automatic clear_monitors();
        hs_cnt   = 0;
        vs_cnt   = 0;
        prev_dhs = 1'b0;
        prev_svs = 1'b0;
        prev_dhc = '0;
        prev_dvc = '0;
    endtask

    task automatic sample_cycle();
        check_dut("def", DHV, DHF, DHS, DHB, DVV, DVF, DVS, DVB,
                  d_hc, d_vc, d_hs, d_vs, d_hb, d_vb, d_fs, d_fc);
        check_dut("sm", SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB,
                  s_hc, s_vc, s_hs, s_vs, s_hb, s_vb, s_fs, s_fc);
        // default raster: hsync pulse shape and vertical step on line wrap
        if (d_hs) hs_cnt++;
        if (d_hc == 11'd1055) begin
            check_val("hs_width", 32'(hs_cnt), 32'd128);
            hs_cnt = 0;
        end
        if (d_hs && !prev_dhs) check_val("hs_rise_col", 32'(d_hc), 32'd840);
        if (!d_hs && prev_dhs) check_val("hs_fall_col", 32'(d_hc), 32'd968);
        if (d_hc == 11'd0 && prev_dhc == 11'd1055)
            check_val("v_step", 32'(d_vc), 32'((int'(prev_dvc) + 1) % 628));
        // small raster: vertical blanking/sync by whole lines
        if (s_vs) vs_cnt++;
        if (s_vs != prev_svs) check_val("vs_edge_col", 32'(s_hc), 32'd0);
        if (s_hc == 11'd0 && s_vc == 11'd10) check_val("vblnk_line10", 32'(s_vb), 32'd1);
        if (s_hc == 11'd0 && s_vc == 11'd11) check_val("vsync_line11", 32'(s_vs), 32'd1);
        if (s_hc == 11'd0 && s_vc == 11'd13) check_val("vsync_line13", 32'(s_vs), 32'd0);
        if (s_hc == 11'd31 && s_vc == 11'd15) begin
            check_val("vs_width", 32'(vs_cnt), 32'd64);
            vs_cnt = 0;
        end
        if (s_fs && exp_q.size() > 0) check_val("fs_time", t, exp_q.pop_front());
        if (t == 3 * S_FRAME) check_val("fcnt_third", 32'(s_fc), FC_EN ? 32'd3 : 32'd0);
        prev_dhs = d_hs;
        prev_svs = s_vs;
        prev_dhc = d_hc;
        prev_dvc = d_vc;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            sample_cycle();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int tgt_h, tgt_v, hold;
        bit found;

        clear_monitors();
        step(3);
        check_reset("def", d_hc, d_vc, d_hs, d_vs, d_hb, d_vb, d_fs, d_fc);
        check_reset("sm",  s_hc, s_vc, s_hs, s_vs, s_hb, s_vb, s_fs, s_fc);

        rst = 1'b1;
        clear_monitors();
        for (int k = 1; k <= 3; k++) exp_q.push_back(32'(k * S_FRAME));
        step(1);
        check_val("first_hcount", 32'(s_hc), 32'd1);
        check_val("first_vcount", 32'(s_vc), 32'd0);
        check_val("first_fstart", 32'(s_fs), 32'd0);
        step(3 * 1056 + $urandom_range(0, 100));
        check_val("fs_pending", 32'(exp_q.size()), 32'd0);

        // abandon a frame at a random mid-frame position
        tgt_h = $urandom_range(1, 31);
        tgt_v = $urandom_range(1, 15);
        found = 1'b0;
        for (int i = 0; i < 2 * S_FRAME && !found; i++) begin
            @(negedge clk);
            sample_cycle();
            if (int'(s_hc) == tgt_h && int'(s_vc) == tgt_v) found = 1'b1;
        end
        check_val("seek_pos", 32'(found), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_reset("def", d_hc, d_vc, d_hs, d_vs, d_hb, d_vb, d_fs, d_fc);
        check_reset("sm",  s_hc, s_vc, s_hs, s_vs, s_hb, s_vb, s_fs, s_fc);
        hold = $urandom_range(1, 4);
        repeat (hold) @(posedge clk);
        #1;
        check_val("held_hcount", 32'(s_hc), 32'd0);
        check_val("held_fstart", 32'(s_fs), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        clear_monitors();
        exp_q.delete();
        exp_q.push_back(32'(S_FRAME));
        exp_q.push_back(32'(2 * S_FRAME));
        step(1);
        check_val("restart_fcnt", 32'(s_fc), 32'd0);
        check_val("restart_hcount", 32'(s_hc), 32'd1);
        step(2 * S_FRAME + $urandom_range(1, 50));
        check_val("fcnt_after_restart", 32'(s_fc), FC_EN ? 32'd2 : 32'd0);
        check_val("fs_pending2", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
